button_conditioner: RTL

- Input-side counterpart of the display path: turns raw push-button levels into clean, synchronous events for the service modules (time set, alarm set, stopwatch, mini game).
- Per-button processing: two-flop synchronizer, then debounce counter, then edge pulses, then hold auto-repeat. Up/down auto-repeat lets time/alarm digits scroll while a button is held.
- Sits between the board push[] pins and the service-module push_* inputs; runs on the divided clk.

---
 rtl/button_conditioner.sv | 106 ++++++++++
 1 files changed

// File: rtl/button_conditioner.sv
// Push-button front end: per-bit 2-flop sync, debounce, press/release pulses, hold auto-repeat.
// Auto-repeat is built only when BTN_REPEAT_EN is defined; otherwise btn_repeat is tied low.
module button_conditioner #(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 10,
  parameter int REPEAT_RATE     = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Elaboration-time guard against unusable timing parameters.
  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1 || REPEAT_RATE > REPEAT_DELAY) begin : g_param_check
    $error("button_conditioner: invalid DEBOUNCE_CYCLES/REPEAT_DELAY/REPEAT_RATE");
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_BTN; gi++) begin : g_btn
      logic             sync1_reg;
      logic             sync2_reg;
      logic [CNT_W-1:0] cnt_reg;
      logic             level_reg;
      logic             press_reg;
      logic             release_reg;
      logic             differ;
      logic             toggle;

      assign differ = (sync2_reg != level_reg);
      // Toggle on the edge where the count would reach DEBOUNCE_CYCLES.
      assign toggle = differ && (cnt_reg == DEB_LAST);

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          sync1_reg   <= 1'b0;
          sync2_reg   <= 1'b0;
          cnt_reg     <= '0;
          level_reg   <= 1'b0;
          press_reg   <= 1'b0;
          release_reg <= 1'b0;
        end else begin
          sync1_reg   <= btn_raw[gi];
          sync2_reg   <= sync1_reg;
          if (!differ || toggle) begin
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
          if (toggle) begin
            level_reg <= ~level_reg;
          end
          press_reg   <= toggle & ~level_reg;
          release_reg <= toggle & level_reg;
        end
      end

      assign btn_level[gi]   = level_reg;
      assign btn_press[gi]   = press_reg;
      assign btn_release[gi] = release_reg;

`ifdef BTN_REPEAT_EN
      localparam int HCNT_W = $clog2(REPEAT_DELAY + 1);
      localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'(REPEAT_DELAY - 1);
      localparam logic [HCNT_W-1:0] RELOAD    = HCNT_W'(REPEAT_DELAY - REPEAT_RATE);

      logic [HCNT_W-1:0] hcnt_reg;
      logic              repeat_reg;

      // A toggle in either direction clears the hold count, so a release edge
      // swallows any repeat that would have fired on it.
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          hcnt_reg   <= '0;
          repeat_reg <= 1'b0;
        end else begin
          repeat_reg <= 1'b0;
          if (toggle) begin
            hcnt_reg <= '0;
          end else if (level_reg) begin
            if (hcnt_reg == HOLD_LAST) begin
              repeat_reg <= 1'b1;
              hcnt_reg   <= RELOAD;
            end else begin
              hcnt_reg <= hcnt_reg + HCNT_W'(1);
            end
          end
        end
      end

      assign btn_repeat[gi] = repeat_reg;
`else
      assign btn_repeat[gi] = 1'b0;
`endif
    end
  endgenerate

endmodule
